axis_upsizer: RTL and testbench
===============================

Name: axis_upsizer

Overview:
- AXI-Stream width up-converter placed directly downstream of the 4-bit register buffer stage.
- Gathers RATIO consecutive DATA_W-bit beats into one DATA_W*RATIO-bit word.
- Presents that word on a registered master interface to the next, wider pipeline stage.
- Sustains one input beat per clock when the downstream side is ready.

Parameters:
DATA_W, 4, width of input beat in bits
RATIO, 4, input beats per output word; legal range 2..16

Ports:
clk_i  input  1  system clock; all logic is rising-edge
arstn_i  input  1  asynchronous reset, active-low
tvalid_i  input  1  slave valid
tready_o  output  1  slave ready
tdata_i  input  DATA_W  slave data
tvalid_o  output  1  master valid
tready_i  input  1  master ready
tdata_o  output  DATA_W*RATIO  master data

Behaviour:
- Interface (already decided): one clock, clk_i. Reset arstn_i is asynchronous and active-low.
- Reset state, applied immediately on arstn_i=0:
  - tvalid_o=0, tdata_o=0.
  - Beat counter cnt=0, accumulator cleared.
  - tready_o reflects the reset state (=1 once out of reset; its value is don't-care while in reset).
- Accept rule: an input beat is accepted when tvalid_i && tready_o. An output word transfers when tvalid_o && tready_i.
- Lane packing is little-endian:
  - The beat accepted at cnt=k goes to accumulator bits [k*DATA_W +: DATA_W].
  - The first beat lands in the LSBs.
- cnt is $clog2(RATIO) bits wide. It increments on each accepted beat and wraps to 0 after the beat at cnt=RATIO-1.
- Word completion: the beat accepted at cnt=RATIO-1 completes the word.
  - On that edge, tdata_o <= {tdata_i, accumulator lanes 0..RATIO-2} and tvalid_o <= 1.
  - Latency: tvalid_o rises one clock after the last beat is accepted.
- tready_o = (cnt != RATIO-1) || !tvalid_o || tready_i.
  - Beats that do not complete a word are always accepted.
  - The completing beat is accepted only if the output register is empty or draining in the same cycle.
  - The combinational path tready_i -> tready_o is permitted; it is exercised only at cnt=RATIO-1.
- Output register:
  - tvalid_o clears on transfer unless a new word completes on the same edge; in that case tvalid_o stays 1 and tdata_o loads the new word.
  - While tvalid_o && !tready_i, tdata_o holds stable (AXI-Stream rule).
- Simultaneous output transfer and completing-beat acceptance gives back-to-back words with no bubble.
- The module never drops or duplicates a beat.
- tvalid_i may deassert between beats of a word; the partial word waits indefinitely.
- Reset mid-word discards the partial accumulator and any held output word.
- Accumulator lanes are not cleared between words. Only tdata_o content at tvalid_o=1 is defined.

Optional Feature:
- Macro: AXIS_UPSIZER_TLAST_EN.
- Defined: adds ports tlast_i (input, 1), tlast_o (output, 1) and tkeep_o (output, RATIO).
  - An accepted beat with tlast_i=1 completes the word early, at any cnt. The same tready_o rule applies, evaluated as if cnt=RATIO-1.
  - Unfilled upper lanes of tdata_o are driven 0.
  - tkeep_o[j]=1 for every filled lane j.
  - tlast_o=1 with that word.
  - cnt returns to 0.
  - tlast_o and tkeep_o reset to 0. Full words without tlast have tkeep_o all ones and tlast_o=0.
- Undefined: none of these ports exist and packing is strictly RATIO beats per word.

Test Plan:
- Reset: hold arstn_i=0 for 400 ns, then release -> tvalid_o=0, tdata_o=0, tready_o=1.
- Streaming: tready_i=1, beats 0x1,0x2,0x3,0x4,0x5,0x6,0x7,0x8 on consecutive cycles.
  - tdata_o=0x4321 one clock after the 4th beat, then 0x8765 one clock after the 8th.
  - tready_o stays 1 throughout.
- Backpressure: tready_i=0, offer 0x1..0x8 continuously.
  - Word 0x4321 is held.
  - Beats 0x5,0x6,0x7 are accepted; tready_o=0 with 0x8 pending.
  - Raise tready_i for 1 cycle -> 0x4321 transfers and 0x8 is accepted on the same edge; tdata_o=0x8765 with no bubble.
- Gapped input: beats 0xC,-,0x3,-,-,0xA,0xF with tvalid_i low in the gaps -> tdata_o=0xFA3C.
- Reset mid-word: accept 0x9,0xB, assert arstn_i=0, release, send 0x1,0x2,0x3,0x4 -> tdata_o=0x4321 with no trace of 0x9/0xB.
- With AXIS_UPSIZER_TLAST_EN: beats 0x5,0x6 (tlast_i on 0x6) -> tdata_o=0x0065, tkeep_o=4'b0011, tlast_o=1. The next 4 beats produce a full word with tkeep_o=4'b1111.

Source files
------------

// File: rtl/axis_upsizer.sv
// axis_upsizer: packs RATIO consecutive DATA_W-bit AXI-Stream beats, little-endian, into one registered wide word.
// Optional macro AXIS_UPSIZER_TLAST_EN adds tlast_i/tlast_o/tkeep_o with early word completion on tlast_i.
module axis_upsizer #(
  parameter int DATA_W = 4,
  parameter int RATIO  = 4
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    tvalid_i,
  output logic                    tready_o,
  input  logic [DATA_W-1:0]       tdata_i,
`ifdef AXIS_UPSIZER_TLAST_EN
  input  logic                    tlast_i,
  output logic                    tlast_o,
  output logic [RATIO-1:0]        tkeep_o,
`endif
  output logic                    tvalid_o,
  input  logic                    tready_i,
  output logic [DATA_W*RATIO-1:0] tdata_o
);

  localparam int                CNT_W    = $clog2(RATIO);
  localparam int                WORD_W   = DATA_W * RATIO;
  localparam int                ACC_W    = DATA_W * (RATIO - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_tvalid;
  logic [WORD_W-1:0] r_tdata;
  logic              w_complete;
  logic              w_tready;
  logic              w_accept;
  logic [WORD_W-1:0] w_word;

`ifdef AXIS_UPSIZER_TLAST_EN
  logic              r_tlast;
  logic [RATIO-1:0]  r_tkeep;
  logic [RATIO-1:0]  w_keep;

  assign w_complete = (r_cnt == LAST_CNT) || tlast_i;
  assign tlast_o    = r_tlast;
  assign tkeep_o    = r_tkeep;
`else
  assign w_complete = (r_cnt == LAST_CNT);
`endif

  // The completing beat may only enter when the output register is empty or draining now
  assign w_tready = !w_complete || !r_tvalid || tready_i;
  assign w_accept = tvalid_i && w_tready;
  assign tready_o = w_tready;
  assign tvalid_o = r_tvalid;
  assign tdata_o  = r_tdata;

  // Assemble the candidate output word: stored lanes below cnt, incoming beat at cnt, zero above
  always_comb begin
    w_word = '0;
    for (int j = 0; j < RATIO - 1; j++) begin
      if (CNT_W'(j) == r_cnt) begin
        w_word[j*DATA_W +: DATA_W] = tdata_i;
      end else if (CNT_W'(j) < r_cnt) begin
        w_word[j*DATA_W +: DATA_W] = r_acc[j*DATA_W +: DATA_W];
      end else begin
        w_word[j*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
    if (r_cnt == LAST_CNT) begin
      w_word[WORD_W-1 -: DATA_W] = tdata_i;
    end else begin
      w_word[WORD_W-1 -: DATA_W] = {DATA_W{1'b0}};
    end
  end

`ifdef AXIS_UPSIZER_TLAST_EN
  // Lane-fill mask for the word being completed
  always_comb begin
    w_keep = '0;
    for (int j = 0; j < RATIO; j++) begin
      if (CNT_W'(j) <= r_cnt) begin
        w_keep[j] = 1'b1;
      end else begin
        w_keep[j] = 1'b0;
      end
    end
  end
`endif

  // Beat counter and partial-word accumulator
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      if (w_complete) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      for (int j = 0; j < RATIO - 1; j++) begin
        if (r_cnt == CNT_W'(j)) begin
          r_acc[j*DATA_W +: DATA_W] <= tdata_i;
        end
      end
    end
  end

  // Output register: loads on word completion, clears on transfer, holds under backpressure
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
`ifdef AXIS_UPSIZER_TLAST_EN
      r_tlast  <= 1'b0;
      r_tkeep  <= '0;
`endif
    end else if (w_accept && w_complete) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_word;
`ifdef AXIS_UPSIZER_TLAST_EN
      r_tlast  <= tlast_i;
      r_tkeep  <= w_keep;
`endif
    end else if (r_tvalid && tready_i) begin
      r_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_upsizer.sv
// Self-checking bench for axis_upsizer: directed scenarios plus randomized traffic against a queue-based model.
module tb_axis_upsizer;

  localparam int DW = 4;
  localparam int R  = 4;
  localparam int WW = DW * R;

  logic          clk;
  logic          arstn;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [WW-1:0] m_tdata;
`ifdef AXIS_UPSIZER_TLAST_EN
  logic          s_tlast;
  logic          m_tlast;
  logic [R-1:0]  m_tkeep;
`endif

  int   total = 0;
  int   bad   = 0;
  logic last_rdy;

  axis_upsizer #(.DATA_W(DW), .RATIO(R)) dut (
    .clk_i    (clk),
    .arstn_i  (arstn),
    .tvalid_i (s_tvalid),
    .tready_o (s_tready),
    .tdata_i  (s_tdata),
`ifdef AXIS_UPSIZER_TLAST_EN
    .tlast_i  (s_tlast),
    .tlast_o  (m_tlast),
    .tkeep_o  (m_tkeep),
`endif
    .tvalid_o (m_tvalid),
    .tready_i (m_tready),
    .tdata_o  (m_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive at negedge, record tready_o, then step past the rising edge
  task automatic beat(input logic v, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    #1;
    last_rdy = s_tready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arstn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
`ifdef AXIS_UPSIZER_TLAST_EN
    s_tlast = 1'b0;
`endif
    #400;
    total++;
    if (m_tvalid !== 1'b0 || m_tdata !== 16'h0000) begin
      bad++; $display("FAIL reset_hold tvalid=%b tdata=%h want 0/0000", m_tvalid, m_tdata);
    end
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (m_tvalid !== 1'b0 || m_tdata !== 16'h0000 || s_tready !== 1'b1) begin
      bad++; $display("FAIL reset_release tvalid=%b tdata=%h tready=%b want 0/0000/1", m_tvalid, m_tdata, s_tready);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      beat(1'b1, DW'(i), 1'b1);
      total++;
      if (last_rdy !== 1'b1) begin
        bad++; $display("FAIL stream_ready beat=%0d got=%b want 1", i, last_rdy);
      end
      if (i == 4 || i == 8) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== ((i == 4) ? 16'h4321 : 16'h8765)) begin
          bad++; $display("FAIL stream_word beat=%0d tvalid=%b tdata=%h", i, m_tvalid, m_tdata);
        end
      end
    end
    beat(1'b0, 4'h0, 1'b1);
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++; $display("FAIL stream_drain tvalid=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 7; i++) begin
      beat(1'b1, DW'(i), 1'b0);
      total++;
      if (last_rdy !== 1'b1) begin
        bad++; $display("FAIL bp_ready beat=%0d got=%b want 1", i, last_rdy);
      end
    end
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h4321) begin
      bad++; $display("FAIL bp_hold tvalid=%b tdata=%h want 1/4321", m_tvalid, m_tdata);
    end
    for (int k = 0; k < 2; k++) begin
      beat(1'b1, 4'h8, 1'b0);
      total++;
      if (last_rdy !== 1'b0 || m_tdata !== 16'h4321) begin
        bad++; $display("FAIL bp_stall tready=%b tdata=%h want 0/4321", last_rdy, m_tdata);
      end
    end
    beat(1'b1, 4'h8, 1'b1);
    total++;
    if (last_rdy !== 1'b1 || m_tvalid !== 1'b1 || m_tdata !== 16'h8765) begin
      bad++; $display("FAIL bp_b2b tready=%b tvalid=%b tdata=%h want 1/1/8765", last_rdy, m_tvalid, m_tdata);
    end
    beat(1'b0, 4'h0, 1'b1);
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++; $display("FAIL bp_drain tvalid=%b want 0", m_tvalid);
    end
  endtask

  task automatic test_gapped();
    logic       vs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] ds[7] = '{4'hC, 4'h0, 4'h3, 4'h0, 4'h0, 4'hA, 4'hF};
    for (int i = 0; i < 7; i++) begin
      beat(vs[i], ds[i], 1'b1);
      if (i < 6) begin
        total++;
        if (m_tvalid !== 1'b0) begin
          bad++; $display("FAIL gap_early step=%0d tvalid=%b want 0", i, m_tvalid);
        end
      end
    end
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'hFA3C) begin
      bad++; $display("FAIL gap_word tvalid=%b tdata=%h want 1/FA3C", m_tvalid, m_tdata);
    end
    beat(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_reset_midword();
    for (int i = 1; i <= 5; i++) beat(1'b1, DW'(i), 1'b0);
    beat(1'b1, 4'h9, 1'b0);
    @(negedge clk);
    arstn = 1'b0; s_tvalid = 1'b0;
    #1;
    total++;
    if (m_tvalid !== 1'b0 || m_tdata !== 16'h0000) begin
      bad++; $display("FAIL rst_async tvalid=%b tdata=%h want 0/0000", m_tvalid, m_tdata);
    end
    @(negedge clk);
    arstn = 1'b1;
    beat(1'b1, 4'h9, 1'b1);
    beat(1'b1, 4'hB, 1'b1);
    @(negedge clk);
    arstn = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    for (int i = 1; i <= 4; i++) beat(1'b1, DW'(i), 1'b1);
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h4321) begin
      bad++; $display("FAIL rst_midword tvalid=%b tdata=%h want 1/4321", m_tvalid, m_tdata);
    end
    beat(1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_random();
    logic [DW-1:0] part[$];
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] w;
    logic          exp_rdy, acc, xfer;
    @(negedge clk);
    arstn = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      s_tvalid = ($urandom_range(0, 9) < 7);
      s_tdata  = DW'($urandom);
      m_tready = ($urandom_range(0, 9) < 5);
      #1;
      exp_rdy = !(part.size() == R - 1 && exp_q.size() != 0 && !m_tready);
      total++;
      if (s_tready !== exp_rdy) begin
        bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", c, s_tready, exp_rdy);
      end
      total++;
      if (m_tvalid !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", c, m_tvalid, exp_q.size() != 0);
      end else if (m_tvalid) begin
        total++;
        if (m_tdata !== exp_q[0]) begin
          bad++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", c, m_tdata, exp_q[0]);
        end
      end
      acc  = s_tvalid && exp_rdy;
      xfer = (exp_q.size() != 0) && m_tready;
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        part.push_back(s_tdata);
        if (part.size() == R) begin
          w = '0;
          for (int k = 0; k < R; k++) w = w + (WW'(part[k]) << (k * DW));
          exp_q.push_back(w);
          part.delete();
        end
      end
      @(posedge clk);
    end
    beat(1'b0, 4'h0, 1'b1);
  endtask

`ifdef AXIS_UPSIZER_TLAST_EN
  task automatic test_tlast();
    @(negedge clk);
    arstn = 1'b0; s_tvalid = 1'b0;
    @(negedge clk);
    arstn = 1'b1;
    beat(1'b1, 4'h5, 1'b1);
    s_tlast = 1'b1;
    beat(1'b1, 4'h6, 1'b1);
    s_tlast = 1'b0;
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h0065 || m_tkeep !== 4'b0011 || m_tlast !== 1'b1) begin
      bad++; $display("FAIL tlast_short tvalid=%b tdata=%h keep=%b last=%b", m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    for (int i = 1; i <= 4; i++) beat(1'b1, DW'(i), 1'b1);
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 16'h4321 || m_tkeep !== 4'b1111 || m_tlast !== 1'b0) begin
      bad++; $display("FAIL tlast_full tvalid=%b tdata=%h keep=%b last=%b", m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    beat(1'b0, 4'h0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_gapped();
    test_reset_midword();
    test_random();
`ifdef AXIS_UPSIZER_TLAST_EN
    test_tlast();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
